operand_stack: RTL and testbench
================================

# operand_stack

Parametrised LIFO operand stack for the stack-machine datapath, replacing the fixed 16×32 stack behind the register-read stage. One clock edge can pop 0, 1 or 2 operands and optionally push one result, so an ALU op such as "pop a, pop b, push a+b" retires in a single cycle. Top-of-stack (TOS) and next-of-stack (NOS) are always presented for operand fetch. Illegal requests are rejected whole and flagged, and a raw peek port gives the bench visibility into the storage.

## Interface
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; any value ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of count; derived, not overridden.
- IDX_W, $clog2(DEPTH), width of peek index; derived.

- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; highest priority after reset.
- push  in  1  push d this cycle.
- pop  in  2  number of entries to pop: 0, 1 or 2; value 3 is illegal.
- d  in  WIDTH  push data.
- tos  out  WIDTH  entry at count-1; 0 when count==0.
- nos  out  WIDTH  entry at count-2; 0 when count<2.
- count  out  CNT_W  number of valid entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- err  out  1  sticky error flag.
- peek_idx  in  IDX_W  raw storage index.
- peek_data  out  WIDTH  storage[peek_idx], combinational; 0 if peek_idx ≥ DEPTH.

## Operation
- Storage is an array of DEPTH×WIDTH entries. count is the stack pointer; index 0 is the bottom.
- A request is legal if all three conditions hold:
  - pop ≤ 2;
  - pop ≤ count;
  - count − pop + push ≤ DEPTH.
- Legal request, when push or pop is nonzero:
  - count_next = count − pop + push.
  - If push is set, d is written to index count − pop. Push therefore overwrites the slot freed by the pop.
- Illegal request:
  - storage and count are unchanged;
  - err is set to 1 and stays set until clr or reset.
- clr: count←0 and err←0. push and pop are ignored in that cycle. Storage is not cleared by clr unless OPSTACK_CLR_ON_POP_EN is defined (see Configuration).
- Boundary cases:
  - push with pop=1 at full is legal (top is replaced).
  - push with pop=0 at full is an overflow.
  - pop=2 at count=1 is an underflow, even with push set.
  - pop=1 with push at count=0 is an underflow.
- tos, nos, empty, full and count are combinational from the registered state.

## Timing
- Reset (asynchronous, while RESET=0):
  - count=0, err=0, all storage entries=0;
  - tos=0, nos=0, empty=1, full=0.
- Latency is 1 cycle. A request sampled at edge N is reflected in tos, nos, count, err and peek_data immediately after edge N.
- There is no handshake or backpressure. The requester must check full, empty and count; a rejected request is lost.
- If reset is asserted mid-operation, all state clears immediately. The first edge after RESET returns high performs a normal operation.
- peek_data follows peek_idx combinationally and reflects storage after the last edge.

## Configuration
- OPSTACK_CLR_ON_POP_EN
  - Defined:
    - every legal pop writes 0 to each vacated slot that is not re-filled by the simultaneous push;
    - clr zeroes all storage.
  - Undefined: vacated slots keep stale data, observable only through peek_data. This saves the write-enable fan-out.
  - tos, nos and count behave identically in both builds.

## Test plan
- Reset, then push 3 then 4 → count=2, tos=4, nos=3, peek_data[0]=3, empty=0.
- With stack [3,4], apply pop=2, push=1, d=7 → count=1, tos=7, nos=0, err=0. With the macro defined, peek_data[1]=0; without it, peek_data[1]=4.
- Push DEPTH values 1..16, then push 99 → full=1, tos=16, count=16, err=1. Then pop=1 with push, d=5 → legal, tos=5, count stays 16.
- From count=1, apply pop=2 → count=1 and tos unchanged, err=1. Then pop=3 → also rejected.
- With err=1 and count=5, assert clr together with push → count=0, err=0, empty=1, no write performed.
- Drop RESET asynchronously between edges while count=3 → count=0, tos=0 and err=0 without waiting for a clock edge.

Source files
------------

// File: rtl/operand_stack_if.sv
// operand_stack_if: request/response bundle of the operand stack.
// The master side (datapath or bench) issues clr/push/pop/d and the peek
// index; the slave side (the stack) returns TOS/NOS, occupancy, the sticky
// error flag and the peeked storage word.
`timescale 1ns/1ps

interface operand_stack_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic             clr;
    logic             push;
    logic [1:0]       pop;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             err;
    logic [IDX_W-1:0] peek_idx;
    logic [WIDTH-1:0] peek_data;

    modport master (
        output clr, push, pop, d, peek_idx,
        input  tos, nos, count, empty, full, err, peek_data
    );

    modport slave (
        input  clr, push, pop, d, peek_idx,
        output tos, nos, count, empty, full, err, peek_data
    );
endinterface

// File: rtl/operand_stack.sv
// operand_stack: parametrised LIFO operand stack for the stack-machine
// datapath. A single edge pops 0, 1 or 2 entries and optionally pushes one
// result, so "pop a, pop b, push a+b" retires in one cycle. Requests that
// would underflow, overflow or use pop=3 are rejected whole and set a
// sticky error flag.
//
// Optional feature macro: OPSTACK_CLR_ON_POP_EN
//   defined   - vacated slots are zeroed on pop and clr zeroes all storage
//   undefined - vacated slots keep stale data (visible only via peek)
`timescale 1ns/1ps

module operand_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    operand_stack_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    logic             active;
    logic             legal;
    logic [CNT_W-1:0] count_next;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] wr_data [DEPTH];

    // Request decode: legality, next occupancy and per-slot write enables.
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a value held and no latch is inferred.
    always_comb begin : decode
        int cnt_i;
        int pop_i;
        int push_i;
        int base;

        cnt_i  = int'(count_q);
        pop_i  = int'(bus.pop);
        push_i = int'(bus.push);
        base   = cnt_i - pop_i;

        active     = bus.push || (bus.pop != 2'd0);
        legal      = (pop_i <= 2) && (pop_i <= cnt_i) && (cnt_i - pop_i + push_i <= DEPTH);
        count_next = CNT_W'(cnt_i - pop_i + push_i);

        for (int i = 0; i < DEPTH; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
        end

        if (bus.clr) begin
`ifdef OPSTACK_CLR_ON_POP_EN
            // Flush wipes the whole array.
            for (int i = 0; i < DEPTH; i++) begin
                wr_en[i] = 1'b1;
            end
`endif
        end else if (active && legal) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.push && (i == base)) begin
                    // The pushed word lands in the lowest slot freed by the pop.
                    wr_en[i]   = 1'b1;
                    wr_data[i] = bus.d;
                end
`ifdef OPSTACK_CLR_ON_POP_EN
                else if ((i >= base) && (i < cnt_i)) begin
                    // Vacated and not re-filled by the push: scrub it.
                    wr_en[i] = 1'b1;
                end
`endif
            end
        end
    end

    // Stack pointer and sticky error flag; clr outranks any request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.clr) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (active) begin
            if (legal) begin
                count_q <= count_next;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage array writes driven by the decoded per-slot enables.
    // NOTE: the array is reset because its contents are architecturally
    // visible on peek_data; a storage array that is never observed before
    // being written would normally be left without reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    storage[i] <= wr_data[i];
                end
            end
        end
    end

    // Operand fetch: TOS/NOS read from the registered pointer, 0 when absent.
    always_comb begin : fetch
        int c;
        c       = int'(count_q);
        bus.tos = '0;
        bus.nos = '0;
        if (c >= 1) begin
            bus.tos = storage[IDX_W'(c - 1)];
        end
        if (c >= 2) begin
            bus.nos = storage[IDX_W'(c - 2)];
        end
    end

    // Raw storage peek; indices beyond the array read as 0.
    always_comb begin
        bus.peek_data = '0;
        if (int'(bus.peek_idx) < DEPTH) begin
            bus.peek_data = storage[bus.peek_idx];
        end
    end

    assign bus.count = count_q;
    assign bus.err   = err_q;
    assign bus.empty = (count_q == '0);
    assign bus.full  = (count_q == CNT_W'(DEPTH));
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed boundary scenarios plus a randomized run,
// compared against a queue-based model of the operand stack.
`timescale 1ns/1ps

module tb_operand_stack;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    operand_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: the stack as a queue (bottom at index 0), plus an
    // image of raw storage for peek, and the sticky error flag.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] store [DEPTH];
    bit               m_err;

    function automatic void model_reset();
        q.delete();
        m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) store[i] = '0;
    endfunction

    function automatic void model_apply(bit c, bit p, int po, logic [WIDTH-1:0] dd);
        int old_n;
        old_n = q.size();
        if (c) begin
            q.delete();
            m_err = 1'b0;
`ifdef OPSTACK_CLR_ON_POP_EN
            for (int i = 0; i < DEPTH; i++) store[i] = '0;
`endif
            return;
        end
        if (!p && po == 0) return;
        if (po > 2 || po > old_n || old_n - po + int'(p) > DEPTH) begin
            m_err = 1'b1;
            return;
        end
        repeat (po) void'(q.pop_back());
        if (p) q.push_back(dd);
`ifdef OPSTACK_CLR_ON_POP_EN
        for (int i = q.size(); i < old_n; i++) store[i] = '0;
`endif
        for (int i = 0; i < q.size(); i++) store[i] = q[i];
    endfunction

    function automatic logic [WIDTH-1:0] m_tos();
        return (q.size() >= 1) ? q[q.size()-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_nos();
        return (q.size() >= 2) ? q[q.size()-2] : '0;
    endfunction

    // Drive one request on the falling edge, let the rising edge take it,
    // update the model, then leave outputs settled for the caller to sample.
    task automatic drive_op(input bit c, input bit p, input logic [1:0] po,
                            input logic [WIDTH-1:0] dd);
        @(negedge CLK);
        bus.clr  = c;
        bus.push = p;
        bus.pop  = po;
        bus.d    = dd;
        @(posedge CLK);
        model_apply(c, p, int'(po), dd);
        #1;
        bus.clr  = 1'b0;
        bus.push = 1'b0;
        bus.pop  = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        bus.clr = 1'b0; bus.push = 1'b0; bus.pop = 2'd0; bus.d = '0; bus.peek_idx = '0;
        RESET = 1'b0;
        model_reset();
        #12;
        vectors++; if (bus.count !== CNT_W'(0)) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        vectors++; if (bus.tos !== '0) begin miscompares++; $display("FAIL reset_tos: got %0h want 0", bus.tos); end
        vectors++; if (bus.nos !== '0) begin miscompares++; $display("FAIL reset_nos: got %0h want 0", bus.nos); end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        vectors++; if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", bus.full); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus.err); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.peek_idx = IDX_W'(i);
            #1;
            vectors++; if (bus.peek_data !== '0) begin miscompares++; $display("FAIL reset_peek[%0d]: got %0h want 0", i, bus.peek_data); end
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_push_basic();
        drive_op(0, 1, 2'd0, 32'd3);
        drive_op(0, 1, 2'd0, 32'd4);
        bus.peek_idx = '0;
        #1;
        vectors++; if (bus.count !== CNT_W'(2)) begin miscompares++; $display("FAIL push34_count: got %0d want 2", bus.count); end
        vectors++; if (bus.tos !== 32'd4) begin miscompares++; $display("FAIL push34_tos: got %0d want 4", bus.tos); end
        vectors++; if (bus.nos !== 32'd3) begin miscompares++; $display("FAIL push34_nos: got %0d want 3", bus.nos); end
        vectors++; if (bus.peek_data !== 32'd3) begin miscompares++; $display("FAIL push34_peek0: got %0d want 3", bus.peek_data); end
        vectors++; if (bus.empty !== 1'b0) begin miscompares++; $display("FAIL push34_empty: got %b want 0", bus.empty); end
    endtask

    task automatic test_pop2_push();
        logic [WIDTH-1:0] exp_peek1;
`ifdef OPSTACK_CLR_ON_POP_EN
        exp_peek1 = '0;
`else
        exp_peek1 = 32'd4;
`endif
        drive_op(0, 1, 2'd2, 32'd7);
        bus.peek_idx = IDX_W'(1);
        #1;
        vectors++; if (bus.count !== CNT_W'(1)) begin miscompares++; $display("FAIL pop2push_count: got %0d want 1", bus.count); end
        vectors++; if (bus.tos !== 32'd7) begin miscompares++; $display("FAIL pop2push_tos: got %0d want 7", bus.tos); end
        vectors++; if (bus.nos !== '0) begin miscompares++; $display("FAIL pop2push_nos: got %0d want 0", bus.nos); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL pop2push_err: got %b want 0", bus.err); end
        vectors++; if (bus.peek_data !== exp_peek1) begin miscompares++; $display("FAIL pop2push_peek1: got %0d want %0d", bus.peek_data, exp_peek1); end
    endtask

    task automatic test_full_overflow();
        drive_op(1, 0, 2'd0, '0);
        for (int v = 1; v <= DEPTH; v++) drive_op(0, 1, 2'd0, WIDTH'(v));
        drive_op(0, 1, 2'd0, 32'd99);
        vectors++; if (bus.full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", bus.full); end
        vectors++; if (bus.tos !== WIDTH'(DEPTH)) begin miscompares++; $display("FAIL ovf_tos: got %0d want %0d", bus.tos, DEPTH); end
        vectors++; if (bus.count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL ovf_count: got %0d want %0d", bus.count, DEPTH); end
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL ovf_err: got %b want 1", bus.err); end
        drive_op(0, 1, 2'd1, 32'd5);
        vectors++; if (bus.tos !== 32'd5) begin miscompares++; $display("FAIL fullrepl_tos: got %0d want 5", bus.tos); end
        vectors++; if (bus.count !== CNT_W'(DEPTH)) begin miscompares++; $display("FAIL fullrepl_count: got %0d want %0d", bus.count, DEPTH); end
        vectors++; if (bus.nos !== WIDTH'(DEPTH - 1)) begin miscompares++; $display("FAIL fullrepl_nos: got %0d want %0d", bus.nos, DEPTH - 1); end
    endtask

    task automatic test_underflow();
        drive_op(1, 0, 2'd0, '0);
        drive_op(0, 1, 2'd0, 32'd8);
        drive_op(0, 1, 2'd2, 32'd11);
        vectors++; if (bus.count !== CNT_W'(1)) begin miscompares++; $display("FAIL udf2_count: got %0d want 1", bus.count); end
        vectors++; if (bus.tos !== 32'd8) begin miscompares++; $display("FAIL udf2_tos: got %0d want 8", bus.tos); end
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL udf2_err: got %b want 1", bus.err); end
        drive_op(1, 0, 2'd0, '0);
        drive_op(0, 1, 2'd0, 32'd8);
        drive_op(0, 0, 2'd3, '0);
        vectors++; if (bus.count !== CNT_W'(1)) begin miscompares++; $display("FAIL pop3_count: got %0d want 1", bus.count); end
        vectors++; if (bus.tos !== 32'd8) begin miscompares++; $display("FAIL pop3_tos: got %0d want 8", bus.tos); end
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL pop3_err: got %b want 1", bus.err); end
        drive_op(1, 0, 2'd0, '0);
        drive_op(0, 1, 2'd1, 32'd9);
        vectors++; if (bus.count !== CNT_W'(0)) begin miscompares++; $display("FAIL udf1push_count: got %0d want 0", bus.count); end
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL udf1push_err: got %b want 1", bus.err); end
    endtask

    task automatic test_clr();
        drive_op(1, 0, 2'd0, '0);
        for (int v = 10; v < 15; v++) drive_op(0, 1, 2'd0, WIDTH'(v));
        drive_op(0, 0, 2'd3, '0);
        vectors++; if (bus.err !== 1'b1 || bus.count !== CNT_W'(5)) begin miscompares++; $display("FAIL clr_setup: got err=%b count=%0d want err=1 count=5", bus.err, bus.count); end
        drive_op(1, 1, 2'd0, 32'd77);
        bus.peek_idx = IDX_W'(5);
        #1;
        vectors++; if (bus.count !== CNT_W'(0)) begin miscompares++; $display("FAIL clr_count: got %0d want 0", bus.count); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL clr_err: got %b want 0", bus.err); end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL clr_empty: got %b want 1", bus.empty); end
        vectors++; if (bus.tos !== '0) begin miscompares++; $display("FAIL clr_tos: got %0d want 0", bus.tos); end
        vectors++; if (bus.peek_data !== store[5]) begin miscompares++; $display("FAIL clr_nowrite_peek5: got %0d want %0d", bus.peek_data, store[5]); end
    endtask

    task automatic test_async_reset();
        drive_op(1, 0, 2'd0, '0);
        for (int v = 21; v < 24; v++) drive_op(0, 1, 2'd0, WIDTH'(v));
        drive_op(0, 0, 2'd3, '0);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        bus.peek_idx = '0;
        #1;
        vectors++; if (bus.count !== CNT_W'(0)) begin miscompares++; $display("FAIL arst_count: got %0d want 0", bus.count); end
        vectors++; if (bus.tos !== '0) begin miscompares++; $display("FAIL arst_tos: got %0d want 0", bus.tos); end
        vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL arst_err: got %b want 0", bus.err); end
        vectors++; if (bus.peek_data !== '0) begin miscompares++; $display("FAIL arst_peek0: got %0d want 0", bus.peek_data); end
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;
        drive_op(0, 1, 2'd0, 32'd42);
        vectors++; if (bus.count !== CNT_W'(1) || bus.tos !== 32'd42) begin miscompares++; $display("FAIL arst_first_op: got count=%0d tos=%0d want count=1 tos=42", bus.count, bus.tos); end
    endtask

    task automatic test_random();
        bit               c;
        bit               p;
        logic [1:0]       po;
        int               r;
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 24) == 0);
            p = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            po = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            bus.peek_idx = IDX_W'($urandom_range(0, DEPTH - 1));
            drive_op(c, p, po, WIDTH'($urandom));
            vectors++; if (bus.count !== CNT_W'(q.size())) begin miscompares++; $display("FAIL rnd%0d_count: got %0d want %0d", n, bus.count, q.size()); end
            vectors++; if (bus.tos !== m_tos()) begin miscompares++; $display("FAIL rnd%0d_tos: got %0h want %0h", n, bus.tos, m_tos()); end
            vectors++; if (bus.nos !== m_nos()) begin miscompares++; $display("FAIL rnd%0d_nos: got %0h want %0h", n, bus.nos, m_nos()); end
            vectors++; if (bus.empty !== (q.size() == 0)) begin miscompares++; $display("FAIL rnd%0d_empty: got %b want %b", n, bus.empty, q.size() == 0); end
            vectors++; if (bus.full !== (q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd%0d_full: got %b want %b", n, bus.full, q.size() == DEPTH); end
            vectors++; if (bus.err !== m_err) begin miscompares++; $display("FAIL rnd%0d_err: got %b want %b", n, bus.err, m_err); end
            vectors++; if (bus.peek_data !== store[bus.peek_idx]) begin miscompares++; $display("FAIL rnd%0d_peek: idx %0d got %0h want %0h", n, bus.peek_idx, bus.peek_data, store[bus.peek_idx]); end
        end
    endtask

    initial begin
        test_reset();
        test_push_basic();
        test_pop2_push();
        test_full_overflow();
        test_underflow();
        test_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
